// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N_REQ producers.
// A winner may keep the port for up to MAX_BURST consecutive writes before the
// priority pointer rotates past it. Cycles with pending requests blocked by a
// full FIFO are counted in a saturating stall counter.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  input  logic                        fifo_full,
  output logic                        fifo_w_en,
  output logic [DATA_WIDTH-1:0]       fifo_data_in,
  output logic [CNT_WIDTH-1:0]        stall_cnt
);

  localparam int unsigned IdxW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [BurstW-1:0]    burst_cnt_q, burst_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic [2*N_REQ-1:0]   req_rot;
  logic [IdxW-1:0]      first_off;
  logic [IdxW:0]        scan_sum;
  logic [IdxW-1:0]      winner;
  logic                 owner_hold;
  logic                 any_req;
  logic                 grant_ok;

  // Next index after v, wrapping at N_REQ-1 (safe for non-power-of-2 N_REQ).
  function automatic logic [IdxW-1:0] wrap_inc(logic [IdxW-1:0] v);
    return (v == IdxW'(N_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  assign any_req  = |req;
  assign grant_ok = any_req && !fifo_full && !clr;

  // Winner: burst owner while it still requests, else first requester from rr_ptr.
  always_comb begin
    owner_hold = (state_q == StBurst) && req[owner_q];
    req_rot    = {req, req} >> rr_ptr_q;
    first_off  = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) first_off = IdxW'(j);
    end
    scan_sum = {1'b0, rr_ptr_q} + {1'b0, first_off};
    if (scan_sum >= (IdxW+1)'(N_REQ)) scan_sum = scan_sum - (IdxW+1)'(N_REQ);
    winner = owner_hold ? owner_q : scan_sum[IdxW-1:0];
  end

  // Grant and write-path outputs; everything is zero unless a write happens.
  always_comb begin
    gnt          = '0;
    fifo_data_in = '0;
    if (grant_ok) begin
      gnt[winner] = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (winner == IdxW'(i)) fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign fifo_w_en = grant_ok;
  assign stall_cnt = stall_cnt_q;

  // Arbitration state advances only on a granted cycle; full or idle cycles hold it.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (grant_ok) begin
      // Owner released mid-burst: rotate past it even if the new winner keeps going.
      if (state_q == StBurst && !req[owner_q]) rr_ptr_d = wrap_inc(owner_q);
      if (state_q == StIdle || winner != owner_q) begin
        owner_d     = winner;
        burst_cnt_d = BurstW'(1);
      end else begin
        burst_cnt_d = burst_cnt_q + 1'b1;
      end
      if (burst_cnt_d == BurstW'(MAX_BURST)) begin
        rr_ptr_d    = wrap_inc(owner_d);
        burst_cnt_d = '0;
        state_d     = StIdle;
      end else begin
        state_d = StBurst;
      end
    end
  end

  // Saturating count of cycles where a request is blocked by a full FIFO.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (any_req && fifo_full && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: two instances share stimulus (N_REQ=4/MAX_BURST=2/16-bit
// counter and N_REQ=3/MAX_BURST=1/4-bit counter) and are compared each cycle against
// a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        fifo_full;

  logic [3:0]  gnt_a;
  logic        w_en_a;
  logic [7:0]  din_a;
  logic [15:0] stall_a;
  logic [2:0]  gnt_b;
  logic        w_en_b;
  logic [7:0]  din_b;
  logic [3:0]  stall_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(2), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .clr(clr), .req(req), .req_data(req_data), .gnt(gnt_a),
    .fifo_full(fifo_full), .fifo_w_en(w_en_a), .fifo_data_in(din_a), .stall_cnt(stall_a)
  );

  fifo_wr_arbiter #(.N_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .clr(clr), .req(req[2:0]), .req_data(req_data[23:0]), .gnt(gnt_b),
    .fifo_full(fifo_full), .fifo_w_en(w_en_b), .fifo_data_in(din_b), .stall_cnt(stall_b)
  );

  // Model: who has priority next, who is mid-burst and for how many writes so far.
  typedef struct {
    int ptr;
    int owner;
    int run;
    bit bursting;
    int stall;
  } mdl_t;

  mdl_t m[2];
  int   nreq[2]   = '{4, 3};
  int   mburst[2] = '{2, 1};
  int   smax[2]   = '{65535, 15};

  function automatic bit req_bit(int i);
    return ((req >> i) & 4'd1) != 4'd0;
  endfunction

  function automatic bit has_req(int k);
    for (int i = 0; i < nreq[k]; i++) if (req_bit(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int winner(int k);
    if (m[k].bursting && req_bit(m[k].owner)) return m[k].owner;
    for (int j = 0; j < nreq[k]; j++) begin
      int i;
      i = (m[k].ptr + j) % nreq[k];
      if (req_bit(i)) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_gnt(int k);
    int w;
    w = winner(k);
    if (clr || fifo_full || w < 0) return 32'd0;
    return 32'd1 << w;
  endfunction

  function automatic logic [31:0] exp_data(int k);
    int w;
    w = winner(k);
    if (clr || fifo_full || w < 0) return 32'd0;
    return (req_data >> (8 * w)) & 32'hFF;
  endfunction

  function automatic logic [31:0] act_gnt(int k);
    return (k == 0) ? 32'(gnt_a) : 32'(gnt_b);
  endfunction
  function automatic logic [31:0] act_wen(int k);
    return (k == 0) ? 32'(w_en_a) : 32'(w_en_b);
  endfunction
  function automatic logic [31:0] act_data(int k);
    return (k == 0) ? 32'(din_a) : 32'(din_b);
  endfunction
  function automatic logic [31:0] act_stall(int k);
    return (k == 0) ? 32'(stall_a) : 32'(stall_b);
  endfunction

  task automatic model_step(int k);
    int w;
    w = winner(k);
    if (clr) begin
      m[k] = '{0, 0, 0, 1'b0, 0};
      return;
    end
    if (has_req(k) && fifo_full && m[k].stall < smax[k]) m[k].stall++;
    if (w >= 0 && !fifo_full) begin
      if (m[k].bursting && !req_bit(m[k].owner)) m[k].ptr = (m[k].owner + 1) % nreq[k];
      if (!m[k].bursting || w != m[k].owner) begin
        m[k].owner = w;
        m[k].run   = 1;
      end else begin
        m[k].run++;
      end
      if (m[k].run == mburst[k]) begin
        m[k].ptr      = (m[k].owner + 1) % nreq[k];
        m[k].run      = 0;
        m[k].bursting = 1'b0;
      end else begin
        m[k].bursting = 1'b1;
      end
    end
  endtask

  // Advance one clock: model consumes the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; req = 4'($urandom); req_data = $urandom; fifo_full = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (act_gnt(k) !== 32'd0 || act_wen(k) !== 32'd0 || act_data(k) !== 32'd0)
        $display("FAIL reset_outputs inst%0d gnt=%h wen=%h data=%h required all 0",
                 k, act_gnt(k), act_wen(k), act_data(k));
      else passed++;
    end
    tick();
    clr = 1'b0; req = 4'b0000;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (act_stall(k) !== 32'd0 || act_gnt(k) !== 32'd0)
        $display("FAIL reset_state inst%0d stall=%h gnt=%h required 0/0",
                 k, act_stall(k), act_gnt(k));
      else passed++;
    end
  endtask

  task automatic test_single();
    fifo_full = 1'b0; req = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      req_data = ($urandom & 32'hFFFF00FF) | 32'h0000_1100;
      #1;
      total++;
      if (gnt_a !== 4'b0010 || w_en_a !== 1'b1 || din_a !== 8'h11)
        $display("FAIL single_a cyc%0d gnt=%b wen=%b data=%h required 0010/1/11",
                 c, gnt_a, w_en_a, din_a);
      else passed++;
      total++;
      if (gnt_b !== 3'b010 || w_en_b !== 1'b1 || din_b !== 8'h11)
        $display("FAIL single_b cyc%0d gnt=%b wen=%b data=%h required 010/1/11",
                 c, gnt_b, w_en_b, din_b);
      else passed++;
      tick();
    end
  endtask

  task automatic test_round_robin();
    int seq_a[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int seq_b[10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
    do_clr();
    req = 4'b1111; fifo_full = 1'b0;
    for (int c = 0; c < 10; c++) begin
      req_data = $urandom;
      #1;
      total++;
      if (gnt_a !== (4'd1 << seq_a[c]) || din_a !== req_data[8*seq_a[c] +: 8])
        $display("FAIL rr_a cyc%0d gnt=%b data=%h required grant to %0d",
                 c, gnt_a, din_a, seq_a[c]);
      else passed++;
      total++;
      if (gnt_b !== (3'd1 << seq_b[c]) || din_b !== req_data[8*seq_b[c] +: 8])
        $display("FAIL rr_b cyc%0d gnt=%b data=%h required grant to %0d",
                 c, gnt_b, din_b, seq_b[c]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_full_stall();
    do_clr();
    req = 4'b1111; fifo_full = 1'b0;
    for (int c = 0; c < 5; c++) tick();  // grants 0,0,1,1,2: owner 2 mid-burst
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (gnt_a !== 4'b0000 || w_en_a !== 1'b0 || gnt_b !== 3'b000 || w_en_b !== 1'b0)
        $display("FAIL full_nogrant cyc%0d gnt_a=%b wen_a=%b gnt_b=%b wen_b=%b required 0",
                 c, gnt_a, w_en_a, gnt_b, w_en_b);
      else passed++;
      tick();
    end
    fifo_full = 1'b0;
    #1;
    total++;
    if (stall_a !== 16'd3) $display("FAIL full_stall_cnt stall=%0d required 3", stall_a);
    else passed++;
    total++;
    if (gnt_a !== 4'b0100) $display("FAIL full_resume gnt=%b required 0100", gnt_a);
    else passed++;
    total++;
    if (32'(gnt_b) !== exp_gnt(1))
      $display("FAIL full_resume_b gnt=%b required %b", gnt_b, exp_gnt(1));
    else passed++;
    tick();
    #1;
    total++;
    if (gnt_a !== 4'b1000) $display("FAIL full_rotate gnt=%b required 1000", gnt_a);
    else passed++;
    tick();
  endtask

  task automatic test_owner_drop();
    do_clr();
    req = 4'b1111; fifo_full = 1'b0;
    #1;
    total++;
    if (gnt_a !== 4'b0001) $display("FAIL drop_first gnt=%b required 0001", gnt_a);
    else passed++;
    tick();
    req = 4'b1110;
    #1;
    total++;
    if (gnt_a !== 4'b0010) $display("FAIL drop_same_cycle gnt=%b required 0010", gnt_a);
    else passed++;
    tick();
    #1;
    total++;
    if (gnt_a !== 4'b0010) $display("FAIL drop_new_burst gnt=%b required 0010", gnt_a);
    else passed++;
    tick();
    #1;
    total++;
    if (gnt_a !== 4'b0100) $display("FAIL drop_burst_end gnt=%b required 0100", gnt_a);
    else passed++;
    tick();
  endtask

  task automatic test_clr_mid();
    do_clr();
    req = 4'b1111; fifo_full = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    fifo_full = 1'b1;
    tick();
    tick();
    fifo_full = 1'b0;
    tick();                              // owner 2 with one write done
    clr = 1'b1;
    #1;
    total++;
    if (gnt_a !== 4'b0000 || w_en_a !== 1'b0 || din_a !== 8'h00)
      $display("FAIL clr_no_write gnt=%b wen=%b data=%h required 0", gnt_a, w_en_a, din_a);
    else passed++;
    tick();
    clr = 1'b0;
    #1;
    total++;
    if (gnt_a !== 4'b0001 || stall_a !== 16'd0)
      $display("FAIL clr_restart gnt=%b stall=%0d required 0001/0", gnt_a, stall_a);
    else passed++;
    total++;
    if (gnt_b !== 3'b001 || stall_b !== 4'd0)
      $display("FAIL clr_restart_b gnt=%b stall=%0d required 001/0", gnt_b, stall_b);
    else passed++;
    tick();
  endtask

  task automatic test_saturate();
    do_clr();
    req = 4'b0001; fifo_full = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      total++;
      if (gnt_a !== 4'b0000 || gnt_b !== 3'b000)
        $display("FAIL sat_nogrant cyc%0d gnt_a=%b gnt_b=%b required 0", c, gnt_a, gnt_b);
      else passed++;
      tick();
    end
    #1;
    total++;
    if (stall_b !== 4'hF) $display("FAIL sat_stall_b stall=%h required f", stall_b);
    else passed++;
    total++;
    if (stall_a !== 16'd20) $display("FAIL sat_stall_a stall=%0d required 20", stall_a);
    else passed++;
    fifo_full = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clr       = ($urandom_range(0, 39) == 0);
      req       = 4'($urandom);
      req_data  = $urandom;
      fifo_full = ($urandom_range(0, 3) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (act_gnt(k) !== exp_gnt(k) || act_wen(k) !== 32'(exp_gnt(k) != 0))
          $display("FAIL rand_gnt inst%0d cyc%0d gnt=%h wen=%h required gnt=%h",
                   k, c, act_gnt(k), act_wen(k), exp_gnt(k));
        else passed++;
        total++;
        if (act_data(k) !== exp_data(k))
          $display("FAIL rand_data inst%0d cyc%0d data=%h required %h",
                   k, c, act_data(k), exp_data(k));
        else passed++;
        total++;
        if (act_stall(k) !== 32'(m[k].stall))
          $display("FAIL rand_stall inst%0d cyc%0d stall=%0d required %0d",
                   k, c, act_stall(k), m[k].stall);
        else passed++;
      end
      tick();
    end
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_owner_drop();
    test_clr_mid();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
